gcd_job_sequencer: RTL
======================

Name: gcd_job_sequencer

Overview:
Host-side driver for the subtractive GCD core. It accepts operand pairs over a valid/ready input and runs the core's start / two-cycle operand-load / done protocol on the core's shared data bus. It returns each result over a valid/ready output. Because the core's DONE state is terminal, the block resets the core after every job. It also bypasses the core for zero operands and aborts hung jobs with a watchdog.

Parameters:
WIDTH, 16, operand/result width
TIMEOUT, 131080, maximum cycles in WAIT before the job is aborted (must be >= 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept a pair
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_gcd  out  WIDTH  GCD result (0 on error)
out_err  out  1  job aborted by watchdog
busy  out  1  job in flight (any state other than INIT/IDLE)
core_rst_n  out  1  active-low reset to the GCD core
core_start  out  1  core start strobe
core_data  out  WIDTH  core shared operand bus
core_done  in  1  core done flag
core_result  in  WIDTH  core A-register value (valid when core_done=1)

Behaviour:
- One clock, async active-low reset. While rst_n=0: state=INIT, in_ready=0, out_valid=0, out_gcd=0, out_err=0, busy=0, core_start=0, core_data=0, core_rst_n=0.
- All core_* outputs are registered, with no combinational paths from core inputs.
- States: INIT, IDLE, START, LOAD_A, LOAD_B, WAIT, CORE_RST, OUT.
- INIT: core_rst_n=0 for exactly one cycle after reset release, then go to IDLE.
- IDLE: in_ready=1 and core_rst_n=1. On in_valid & in_ready, latch a_q=in_a and b_q=in_b.
  - If a_q==0 or b_q==0: out_gcd = in_a | in_b, out_err=0, go to OUT. out_valid rises the cycle after acceptance, and the core is untouched.
  - Otherwise go to START.
- Core protocol, cycle-exact on the core pins:
  - Cycle k: core_start=1, core_data=0.
  - Cycle k+1: core_data=A, core_start=0.
  - Cycle k+2: core_data=B.
  - From k+3 onward: core_data=0.
  - core_start is high for exactly one cycle per job.
- WAIT: the watchdog counter clears on entry and increments each cycle.
  - core_done=1: capture out_gcd=core_result, out_err=0, go to CORE_RST.
  - Else if count == TIMEOUT-1: out_gcd=0, out_err=1, go to CORE_RST.
  - If core_done and timeout hit in the same cycle, done wins.
- CORE_RST: core_rst_n=0 for exactly one cycle, then go to OUT.
- OUT: out_valid=1. out_gcd and out_err stay stable until out_ready=1. On the handshake cycle, go to IDLE; out_valid drops the next cycle.
- No pipelining: one job at a time. in_ready=0 from the acceptance cycle+1 until return to IDLE. in_valid is ignored outside IDLE.
- Latency, nonzero operands: acceptance at T, core_start at T+1, result out_valid 2 cycles after the cycle core_done is sampled high.
- Widths:
  - out_gcd is WIDTH bits and never exceeds max(in_a, in_b).
  - The counter width is $clog2(TIMEOUT+1), and the counter saturates at TIMEOUT-1.
- Reset mid-operation: any state returns to INIT immediately. core_rst_n=0 asynchronously; the pending job and result are discarded.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Package gcd_pkg: state enum type, default WIDTH and TIMEOUT constants, core protocol offsets (LOAD_A_OFS=1, LOAD_B_OFS=2).
- One sub-module, gcd_watchdog: clear/enable counter with terminal-count output parameterised by TIMEOUT.
- The FSM, operand latches and core-interface registers stay in gcd_job_sequencer.

Test Plan:
- (48,18) with the real GCD core, out_ready=1 -> core_start exactly 1 cycle, core_data 48 then 18 on the next two cycles; out_gcd=6, out_err=0; one-cycle core_rst_n low pulse before out_valid.
- Zero bypass: (0,35) -> out_gcd=35 one cycle after acceptance, no core_start. (0,0) -> out_gcd=0, out_err=0.
- Backpressure: (21,14), out_ready held 0 for 5 cycles after out_valid -> out_valid, out_gcd=7 and out_err stable; in_ready=0 throughout; IDLE after the handshake.
- Watchdog: core stub never asserts core_done, TIMEOUT=8 -> after 8 WAIT cycles out_err=1, out_gcd=0, core_rst_n low 1 cycle; next job (9,6) on the real core gives 3.
- Reset mid-WAIT: rst_n low during job (100,75) -> all outputs at reset values within the same cycle; after release, INIT then IDLE; (100,75) resubmitted gives 25.
- Back-to-back: 4 pairs with in_valid always high -> each accepted only in IDLE, results in order 6, 1, 5, 12 for (48,18), (17,5), (25,10), (36,24).

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD job sequencer.
//   state_t       : sequencer FSM states
//   DEF_WIDTH     : default operand/result width
//   DEF_TIMEOUT   : default watchdog limit in WAIT cycles
//   LOAD_A_OFS/B  : cycles after the core_start strobe at which A/B sit on core_data
package gcd_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 131080;

  // Core bus timeline relative to the core_start cycle. The FSM walks
  // START -> LOAD_A -> LOAD_B, one state per offset.
  localparam int LOAD_A_OFS = 1;
  localparam int LOAD_B_OFS = 2;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_START,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_CORE_RST,
    S_OUT
  } state_t;

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Host-side job interface of the GCD sequencer.
//   in_valid/in_ready/in_a/in_b     : operand pair handshake
//   out_valid/out_ready/out_gcd/out_err : result handshake
//   master : the host issuing jobs; slave : the sequencer
interface gcd_job_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_gcd, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_gcd, out_err
  );
endinterface

// File: rtl/gcd_watchdog.sv
// Clear/enable cycle counter with terminal-count flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   tc         : high while count == TIMEOUT-1; count saturates there
module gcd_watchdog
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Host-side driver for the subtractive GCD core.
//   clk, rst_n   : clock, async active-low reset
//   host         : job interface (slave side): operand pair in, result/err out
//   busy         : job in flight (state other than INIT/IDLE)
//   core_rst_n   : registered active-low reset to the core, pulsed after each job
//   core_start   : one-cycle start strobe
//   core_data    : shared operand bus (0, A, B, then 0)
//   core_done    : core finished flag
//   core_result  : core A register, valid with core_done
// Zero operands bypass the core; a watchdog aborts jobs stuck in WAIT.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_job_sequencer_if.slave host,
  output logic             busy,
  output logic             core_rst_n,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             wd_tc;

  // Counter is cleared while presenting B so that it reads 0 on the
  // first WAIT cycle; TIMEOUT WAIT cycles elapse before abort.
  gcd_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == S_LOAD_B),
    .en    (state == S_WAIT),
    .tc    (wd_tc)
  );

  assign busy = !(state == S_INIT || state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_INIT;
      a_q            <= '0;
      b_q            <= '0;
      host.in_ready  <= 1'b0;
      host.out_valid <= 1'b0;
      host.out_gcd   <= '0;
      host.out_err   <= 1'b0;
      core_rst_n     <= 1'b0;
      core_start     <= 1'b0;
      core_data      <= '0;
    end else begin
      case (state)
        S_INIT: begin
          core_rst_n    <= 1'b1;
          host.in_ready <= 1'b1;
          state         <= S_IDLE;
        end
        S_IDLE: begin
          if (host.in_valid && host.in_ready) begin
            a_q           <= host.in_a;
            b_q           <= host.in_b;
            host.in_ready <= 1'b0;
            if (host.in_a == '0 || host.in_b == '0) begin
              // gcd(x,0)=x and gcd(0,0)=0: the OR covers all zero cases
              host.out_gcd   <= host.in_a | host.in_b;
              host.out_err   <= 1'b0;
              host.out_valid <= 1'b1;
              state          <= S_OUT;
            end else begin
              core_start <= 1'b1;
              core_data  <= '0;
              state      <= S_START;
            end
          end
        end
        S_START: begin
          core_start <= 1'b0;
          core_data  <= a_q;
          state      <= S_LOAD_A;
        end
        S_LOAD_A: begin
          core_data <= b_q;
          state     <= S_LOAD_B;
        end
        S_LOAD_B: begin
          core_data <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so it wins over a same-cycle timeout
          if (core_done) begin
            host.out_gcd <= core_result;
            host.out_err <= 1'b0;
            core_rst_n   <= 1'b0;
            state        <= S_CORE_RST;
          end else if (wd_tc) begin
            host.out_gcd <= '0;
            host.out_err <= 1'b1;
            core_rst_n   <= 1'b0;
            state        <= S_CORE_RST;
          end
        end
        S_CORE_RST: begin
          // core DONE is terminal, so it is reset before every new job
          core_rst_n     <= 1'b1;
          host.out_valid <= 1'b1;
          state          <= S_OUT;
        end
        S_OUT: begin
          if (host.out_ready) begin
            host.out_valid <= 1'b0;
            host.in_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
